// File: rtl/shift_pipe_pkg.sv
// ============================================================================
// Module   : shift_pipe_pkg
// Brief    : Shared constants and helpers for the shift_pipe elastic pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pipe_pkg;

    localparam int c_DEFAULT_WIDTH = 4;
    localparam int c_DEFAULT_DEPTH = 2;
    localparam int c_PAR_MAX_W     = 64;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Callers zero-extend narrower data; zero bits do not disturb parity.
    function automatic logic even_parity(input logic [c_PAR_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_pipe_stage.sv
// ============================================================================
// Module   : shift_pipe_stage
// Brief    : One valid+data register of the shift pipeline with load/clear.
//            Carries a parity bit when SHIFT_PIPE_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
`ifdef SHIFT_PIPE_PARITY_EN
    input  logic             src_par,
    output logic             par,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Data only moves when a valid word arrives, so empty stages stay quiet.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = src_valid;
            if (src_valid) begin
                data_d = src_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

`ifdef SHIFT_PIPE_PARITY_EN
    logic par_d;
    logic par_q;

    always_comb begin
        par_d = par_q;
        if (!clear && load && src_valid) begin
            par_d = src_par;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par = par_q;
`endif

endmodule

`default_nettype wire

// File: rtl/shift_pipe.sv
// ============================================================================
// Module   : shift_pipe
// Brief    : Parametrised elastic shift pipeline with valid/ready at both ends,
//            bubble collapsing, flush, tap port and occupancy count.
//            Macro SHIFT_PIPE_PARITY_EN adds per-stage parity and par_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int TAP   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    input  logic                            out_ready,
    input  logic                            flush,
    output logic                            tap_valid,
    output logic [WIDTH-1:0]                tap_data,
    output logic [count_width(DEPTH)-1:0]   count,
    output logic                            par_err
);

    localparam int                 c_CNT_W   = count_width(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_src_valid;
    logic [DEPTH-1:0] w_adv;
    logic [WIDTH-1:0] w_data     [DEPTH];
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic             w_accept;
    logic             w_xfer;

    // A stage may advance when the output drains or any stage at or beyond it is empty.
    always_comb begin : p_adv
        logic all_full;
        all_full = 1'b1;
        w_adv    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & w_valid[i];
            w_adv[i] = out_ready | ~all_full;
        end
    end

    assign in_ready = w_adv[0] & ~flush;
    assign w_accept = in_valid & in_ready;
    assign w_xfer   = out_valid & out_ready;

`ifdef SHIFT_PIPE_PARITY_EN
    logic [DEPTH-1:0]       w_par;
    logic [DEPTH-1:0]       w_src_par;
    logic [c_PAR_MAX_W-1:0] w_in_ext;
    logic [c_PAR_MAX_W-1:0] w_out_ext;

    always_comb begin
        w_in_ext               = '0;
        w_in_ext[WIDTH-1:0]    = in_data;
        w_out_ext              = '0;
        w_out_ext[WIDTH-1:0]   = w_data[DEPTH-1];
    end
`endif

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_src_in
            assign w_src_valid[gi] = w_accept;
            assign w_src_data[gi]  = in_data;
`ifdef SHIFT_PIPE_PARITY_EN
            assign w_src_par[gi]   = even_parity(w_in_ext);
`endif
        end else begin : g_src_prev
            assign w_src_valid[gi] = w_valid[gi-1];
            assign w_src_data[gi]  = w_data[gi-1];
`ifdef SHIFT_PIPE_PARITY_EN
            assign w_src_par[gi]   = w_par[gi-1];
`endif
        end

        shift_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush),
            .load      (w_adv[gi]),
            .src_valid (w_src_valid[gi]),
            .src_data  (w_src_data[gi]),
`ifdef SHIFT_PIPE_PARITY_EN
            .src_par   (w_src_par[gi]),
            .par       (w_par[gi]),
`endif
            .valid     (w_valid[gi]),
            .data      (w_data[gi])
        );
    end

    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign tap_valid = w_valid[TAP];
    assign tap_data  = w_data[TAP];

    logic [c_CNT_W-1:0] count_d;
    logic [c_CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (w_accept && !w_xfer) begin
            count_d = count_q + c_CNT_ONE;
        end else if (!w_accept && w_xfer) begin
            count_d = count_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef SHIFT_PIPE_PARITY_EN
    logic par_err_d;
    logic par_err_q;

    // Parity is rechecked only on words actually delivered downstream.
    always_comb begin
        par_err_d = par_err_q;
        if (flush) begin
            par_err_d = 1'b0;
        end else if (w_xfer && (even_parity(w_out_ext) != w_par[DEPTH-1])) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_pipe.sv
// ============================================================================
// Module   : tb_shift_pipe
// Brief    : Self-checking bench for shift_pipe (DEPTH=2 and DEPTH=4 instances).
//            Parity scenario compiled when SHIFT_PIPE_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_iv = 1'b0, a_ordy = 1'b0, a_fl = 1'b0;
    logic [3:0] a_id = 4'h0;
    logic       a_ir, a_ov, a_tv, a_pe;
    logic [3:0] a_od, a_td;
    logic [1:0] a_cnt;

    logic       b_iv = 1'b0, b_ordy = 1'b0, b_fl = 1'b0;
    logic [3:0] b_id = 4'h0;
    logic       b_ir, b_ov, b_tv, b_pe;
    logic [3:0] b_od, b_td;
    logic [2:0] b_cnt;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(4), .DEPTH(2), .TAP(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_ordy), .flush(a_fl),
        .tap_valid(a_tv), .tap_data(a_td), .count(a_cnt), .par_err(a_pe)
    );

    shift_pipe #(.WIDTH(4), .DEPTH(4), .TAP(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_ordy), .flush(b_fl),
        .tap_valid(b_tv), .tap_data(b_td), .count(b_cnt), .par_err(b_pe)
    );

    // Model: per instance, an ordered list of words (oldest first) with their positions.
    logic [3:0] md [2][8];
    int         mp [2][8];
    int         mn [2] = '{0, 0};

    int  n_err = 0;
    int  n_chk = 0;
    logic cmp_a_en = 1'b1;

    logic [3:0] t1_seq [5] = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2};
    logic [3:0] t3_seq [3] = '{4'h6, 4'hC, 4'hE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A word moves one place unless it sits in a solid stalled block ending at the output.
    task automatic model_step(input int k, input int d, input logic iv, input logic [3:0] id,
                              input logic ordy, input logic fl);
        logic [3:0] nd [8];
        int         np [8];
        int         keep;
        keep = 0;
        if (fl) begin
            mn[k] = 0;
            return;
        end
        for (int j = 0; j < mn[k]; j++) begin
            if (mp[k][j] == d - 1) begin
                if (!ordy) begin
                    nd[keep] = md[k][j];
                    np[keep] = d - 1;
                    keep++;
                end
            end else begin
                nd[keep] = md[k][j];
                np[keep] = (ordy || j < d - 1 - mp[k][j]) ? mp[k][j] + 1 : mp[k][j];
                keep++;
            end
        end
        if (iv && (ordy || mn[k] < d)) begin
            nd[keep] = id;
            np[keep] = 0;
            keep++;
        end
        for (int j = 0; j < keep; j++) begin
            md[k][j] = nd[j];
            mp[k][j] = np[j];
        end
        mn[k] = keep;
    endtask

    task automatic cmp_inst(input string p, input int k, input int d, input int tap,
                            input logic ir, input logic ov, input logic [3:0] od,
                            input logic tv, input logic [3:0] td, input logic [31:0] cnt,
                            input logic pe, input logic ordy, input logic fl);
        logic       e_ov, e_tv;
        logic [3:0] e_td;
        e_ov = (mn[k] > 0) && (mp[k][0] == d - 1);
        e_tv = 1'b0;
        e_td = 4'h0;
        for (int j = 0; j < mn[k]; j++) begin
            if (mp[k][j] == tap) begin
                e_tv = 1'b1;
                e_td = md[k][j];
            end
        end
        check({p, ".out_valid"}, ov, e_ov);
        if (e_ov) check({p, ".out_data"}, od, md[k][0]);
        check({p, ".in_ready"}, ir, !fl && (ordy || mn[k] < d));
        check({p, ".count"}, cnt, mn[k]);
        check({p, ".tap_valid"}, tv, e_tv);
        if (e_tv) check({p, ".tap_data"}, td, e_td);
        check({p, ".par_err"}, pe, 1'b0);
    endtask

    task automatic cyc();
        @(negedge clk);
        if (cmp_a_en) cmp_inst("a", 0, 2, 0, a_ir, a_ov, a_od, a_tv, a_td, a_cnt, a_pe, a_ordy, a_fl);
        cmp_inst("b", 1, 4, 1, b_ir, b_ov, b_od, b_tv, b_td, b_cnt, b_pe, b_ordy, b_fl);
        @(posedge clk);
        if (!rst) begin
            model_step(0, 2, a_iv, a_id, a_ordy, a_fl);
            model_step(1, 4, b_iv, b_id, b_ordy, b_fl);
        end
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) cyc();
        check("rst.a_out_valid", a_ov, 0);
        check("rst.a_count", a_cnt, 0);
        check("rst.a_out_data", a_od, 0);
        check("rst.b_out_valid", b_ov, 0);
        check("rst.b_count", b_cnt, 0);
        check("rst.b_tap_valid", b_tv, 0);
        rst = 1'b0;
        cyc();

        // 1: DEPTH=2 back-to-back stream, latency 2
        a_ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_iv = (i < 5);
            a_id = (i < 5) ? t1_seq[i] : 4'h0;
            if (i >= 2 && i < 7) begin
                check("t1.out_valid", a_ov, 1);
                check("t1.out_data", a_od, t1_seq[i-2]);
            end
            if (i == 7) check("t1.drained", a_ov, 0);
            cyc();
        end

        // 2: DEPTH=4 stalled, 5 pushes -> 4 accepted, then in-order drain
        b_ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_iv = 1'b1;
            b_id = 4'(i + 1);
            cyc();
        end
        #1;
        check("t2.count_full", b_cnt, 4);
        check("t2.in_ready_full", b_ir, 0);
        b_ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2.out_valid", b_ov, 1);
            check("t2.out_data", b_od, i + 1);
            cyc();
            if (i == 0) b_iv = 1'b0;
        end
        repeat (2) cyc();

        // 3: bubble collapse under output stall
        b_ordy = 1'b0;
        b_iv = 1'b1;
        b_id = 4'h9;
        cyc();
        b_iv = 1'b0;
        repeat (3) cyc();
        #1;
        check("t3.out_valid", b_ov, 1);
        check("t3.out_data", b_od, 4'h9);
        check("t3.count", b_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            b_iv = 1'b1;
            b_id = t3_seq[i];
            #1;
            check("t3.in_ready", b_ir, 1);
            cyc();
        end
        b_iv = 1'b0;
        #1;
        check("t3.count_full", b_cnt, 4);
        b_ordy = 1'b1;
        repeat (6) cyc();

        // 4: flush of a full pipe with concurrent input
        b_ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_iv = 1'b1;
            b_id = 4'(8 + i);
            cyc();
        end
        b_fl = 1'b1;
        b_id = 4'hD;
        #1;
        check("t4.in_ready_flush", b_ir, 0);
        check("t4.out_valid_flush", b_ov, 1);
        cyc();
        b_fl = 1'b0;
        b_iv = 1'b0;
        #1;
        check("t4.count", b_cnt, 0);
        check("t4.out_valid", b_ov, 0);
        b_ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t4.no_emit", b_ov, 0);
            cyc();
        end

        // 5: asynchronous reset pulse mid-stream, then latency from restart
        for (int i = 0; i < 5; i++) begin
            b_iv = 1'b1;
            b_id = 4'(i + 1);
            cyc();
        end
        b_iv = 1'b0;
        #1;
        check("t5.pre_out_valid", b_ov, 1);
        rst = 1'b1;
        mn[0] = 0;
        mn[1] = 0;
        #1;
        check("t5.rst_out_valid", b_ov, 0);
        check("t5.rst_count", b_cnt, 0);
        check("t5.rst_tap_valid", b_tv, 0);
        rst = 1'b0;
        cyc();
        b_iv = 1'b1;
        b_id = 4'hB;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            if (j == 1) b_iv = 1'b0;
            #1;
            check("t5.latency", b_ov, (j == 4));
            if (j == 4) check("t5.out_data", b_od, 4'hB);
        end
        repeat (2) cyc();

`ifdef SHIFT_PIPE_PARITY_EN
        // 6: corrupt stored data, expect sticky parity error until flush
        a_ordy = 1'b0;
        a_iv = 1'b1;
        a_id = 4'h5;
        cyc();
        a_iv = 1'b0;
        cyc();
        cmp_a_en = 1'b0;
        force dut_a.g_stage[1].u_stage.data_q = 4'h4;
        #1;
        check("t6.par_err_before", a_pe, 0);
        a_ordy = 1'b1;
        cyc();
        release dut_a.g_stage[1].u_stage.data_q;
        a_ordy = 1'b0;
        #1;
        check("t6.par_err_set", a_pe, 1);
        cyc();
        check("t6.par_err_held", a_pe, 1);
        a_fl = 1'b1;
        cyc();
        a_fl = 1'b0;
        #1;
        check("t6.par_err_cleared", a_pe, 0);
        cmp_a_en = 1'b1;
        cyc();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
